uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Receive-side UART engine that deserialises 8N1 frames from the `rx` pin into bytes. It holds the received byte until the controller acknowledges it with `read_uart`. It runs on the same 25 MHz `clk` as the transmit path and feeds `data_out` / `rx_available` to the board LEDs through the UART controller. It adds false-start rejection, framing-error and overrun detection, and an asynchronous active-low reset.

## Interface
- `CLKS_PER_BIT`, default 217: clk cycles per bit (25 MHz / 115200 baud); must be ≥ 4.
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx`  in  1  raw UART serial input, idle high, asynchronous to `clk`
- `read_uart`  in  1  level-sensitive acknowledge; clears `rx_available`, `frame_error`, `overrun` while high
- `data_out`  out  8  last good received byte
- `rx_available`  out  1  byte waiting in `data_out`
- `frame_error`  out  1  sticky: a stop bit was sampled low
- `overrun`  out  1  sticky: a good byte arrived while `rx_available` was 1 and was dropped

## Operation
- `rx` passes through a 2-flop synchroniser (reset to 1) to give `rx_s`; `rx_s` is registered once more as `rx_d` for edge detection.
- Bit counter is 3 bits; the cycle counter is wide enough for `CLKS_PER_BIT-1`.
- State machine states:
  - IDLE: on `rx_d`=1 and `rx_s`=0 (falling edge), load cycle counter with `CLKS_PER_BIT/2` (integer) and go to START.
  - START: when the counter expires, sample `rx_s`. If 1, the start is false: return to IDLE with no flags. If 0, reload `CLKS_PER_BIT` and go to DATA with bit index 0.
  - DATA: on each expiry, shift `rx_s` into the shift register LSB-first. After bit index 7, go to STOP. Otherwise increment the index and reload.
  - STOP: on expiry, sample `rx_s`.
    - If 1 and (`rx_available`=0 or `read_uart`=1): load `data_out` and set `rx_available`.
    - If 1 and `rx_available`=1 and `read_uart`=0: keep `data_out`, set `overrun`.
    - If 0: set `frame_error` and discard the byte.
    - In all three cases, go to IDLE.
- Because IDLE needs a 1→0 edge, a line held low after a framing error (break) is not re-triggered until `rx` returns high.
- `read_uart` high clears `rx_available`, `overrun` and `frame_error` on every edge. A set event on the same edge takes priority over the clear.
- `data_out` changes only on a good stop bit; it is never cleared except by reset.

## Timing
- Reset values (`rst_n`=0, asynchronous): state IDLE, counters 0, shift register 0, sync flops 1, `data_out`=8'h00, `rx_available`=0, `frame_error`=0, `overrun`=0.
- T0 is the first clk edge that samples `rx`=0 at a start bit.
  - `rx_s` goes low after edge T0+1; the falling edge is detected at edge T0+2.
  - Start sample at T0+2+`CLKS_PER_BIT/2`.
  - Data bit i sample at T0+2+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop sample at T0+2+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
  - `data_out`, `rx_available`, `frame_error` and `overrun` update on the stop-sample edge and are visible the following cycle.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving 0.5 bit later is accepted with no gap required.
- Reset asserted mid-frame aborts immediately. After release, the next frame is received correctly only from a fresh high→low edge.
- `read_uart` may be held high indefinitely. Bytes completing while it is high still load `data_out` and `rx_available`=1, and clear again on the next edge.

## Test plan
Bench settings: `CLKS_PER_BIT`=16 unless stated; frames are driven at the exact bit period.
- Reset, then send 8'hA5 with good stop → `rx_available` rises exactly 2+8+144 cycles after T0; `data_out`=8'hA5; `frame_error`=`overrun`=0; pulse `read_uart` → `rx_available`=0, `data_out` still 8'hA5.
- Send 8'h3C then 8'hC3 back-to-back without `read_uart` → `data_out`=8'h3C, `rx_available`=1, `overrun`=1; `read_uart` clears both flags.
- Send 8'h55 with stop bit 0, then `rx` high → `frame_error`=1, `rx_available`=0, `data_out` unchanged; following 8'h0F frame → `data_out`=8'h0F.
- Glitch: `rx` low for 4 cycles then high → returns to IDLE, no flag changes; next valid 8'hFF is received correctly.
- Hold `read_uart`=1 while 8'h81 completes → `data_out`=8'h81, `rx_available` high for exactly 1 cycle, no overrun.
- Assert `rst_n`=0 during data bit 3, release, send 8'h7E → all outputs were 0 during reset; `data_out`=8'h7E after the frame.

Source files
------------

// File: rtl/uart_rx_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_engine
//
// Receives 8N1 UART frames on rx and turns them into bytes. Each received
// byte is held until the controller acknowledges it with read_uart. The
// engine rejects false starts and detects framing errors and overruns.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit time (must be >= 4)
//
// Ports
//   clk           single clock; all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   rx            raw serial input; idle high; asynchronous to clk
//   read_uart     level acknowledge; clears rx_available, frame_error and
//                 overrun while it is high
//   data_out      last byte received with a good stop bit
//   rx_available  a byte is waiting in data_out
//   frame_error   sticky: a stop bit was sampled low
//   overrun       sticky: a good byte arrived while rx_available was set,
//                 and that byte was dropped
// ---------------------------------------------------------------------------
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       read_uart,
  output logic [7:0] data_out,
  output logic       rx_available,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // The counter expires when it reaches zero, so each load value is one less
  // than the number of cycles to wait.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Two-flop synchroniser (rx_p0 -> rx_s), plus rx_d for edge detection.
  logic rx_p0;
  logic rx_s;
  logic rx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0        <= 1'b1;
      rx_s         <= 1'b1;
      rx_d         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      data_out     <= '0;
      rx_available <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
      rx_d  <= rx_s;

      // The acknowledge clear comes first, so that a set from the FSM below
      // on the same edge overrides it.
      if (read_uart) begin
        rx_available <= 1'b0;
        frame_error  <= 1'b0;
        overrun      <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A real 1->0 edge is required. A line held low after a break
          // does not retrigger the receiver.
          if (rx_d && !rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              // The line is high again at mid start bit: a glitch.
              state <= IDLE;
            end else begin
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            // The frame is LSB first: shift right and insert at the MSB.
            shift <= {rx_s, shift[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              if (!rx_available || read_uart) begin
                data_out     <= shift;
                rx_available <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
            end
            // The FSM returns to IDLE at mid stop bit. This lets a
            // back-to-back start edge be caught with no gap.
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
`timescale 1ns/1ps
module tb_uart_rx_engine;

  localparam int C = 16;
  // Stop-sample edge relative to T0: 2 + C/2 + 9*C = 154 for C = 16.
  localparam int STOP_OFS = 2 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       read_uart = 1'b0;
  logic [7:0] data_out;
  logic       rx_available;
  logic       frame_error;
  logic       overrun;

  uart_rx_engine #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .read_uart    (read_uart),
    .data_out     (data_out),
    .rx_available (rx_available),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       av;
    logic       fe;
    logic       ov;
    int         cyc;
    bit         pulse;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // The caller must already be at a negedge. Drives one frame at the exact
  // bit period and queues the hand-computed outcome. The line is returned
  // high at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic [7:0] ed, input logic eav,
                            input logic efe, input logic eov, input bit pulse);
    exp_t e;
    e.d = ed; e.av = eav; e.fe = efe; e.ov = eov; e.pulse = pulse;
    e.cyc = cyc + 1 + STOP_OFS;
    q.push_back(e);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    read_uart = 1'b1;
    @(negedge clk);
    read_uart = 1'b0;
  endtask

  // Monitor: a rising rx_available, frame_error or overrun is an event.
  logic pav = 1'b0, pfe = 1'b0, pov = 1'b0;
  bit   pend_fall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (pend_fall) begin
      check("avail_one_cycle", {31'd0, rx_available}, 32'd0);
      pend_fall = 1'b0;
    end
    if (rst_n && ((rx_available && !pav) || (frame_error && !pfe) || (overrun && !pov))) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual=%h/%b%b%b required=none (cycle %0d)",
                 data_out, rx_available, frame_error, overrun, cyc);
      end else begin
        e = q.pop_front();
        check("evt_outputs", {21'd0, data_out, rx_available, frame_error, overrun},
              {21'd0, e.d, e.av, e.fe, e.ov});
        check("evt_cycle", cyc, e.cyc);
        if (e.pulse) pend_fall = 1'b1;
      end
    end
    pav = rx_available;
    pfe = frame_error;
    pov = overrun;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, data_out}, 32'h00);
    check("rst_avail", {31'd0, rx_available}, 0);
    check("rst_fe",    {31'd0, frame_error}, 0);
    check("rst_ov",    {31'd0, overrun}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic A5 frame, exact latency, then acknowledge.
    send_frame(8'hA5, 1'b1, 8'hA5, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    pulse_read();
    check("a5_avail_cleared", {31'd0, rx_available}, 0);
    check("a5_data_kept", {24'd0, data_out}, 32'hA5);
    repeat (5) @(negedge clk);

    // Overrun: back-to-back frames with no acknowledge.
    send_frame(8'h3C, 1'b1, 8'h3C, 1, 0, 0, 0);
    send_frame(8'hC3, 1'b1, 8'h3C, 1, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("ovr_data", {24'd0, data_out}, 32'h3C);
    pulse_read();
    check("ovr_avail_cleared", {31'd0, rx_available}, 0);
    check("ovr_ov_cleared", {31'd0, overrun}, 0);
    repeat (5) @(negedge clk);

    // Framing error, then a good frame. frame_error stays sticky.
    send_frame(8'h55, 1'b0, 8'h3C, 0, 1, 0, 0);
    repeat (C) @(negedge clk);
    send_frame(8'h0F, 1'b1, 8'h0F, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    pulse_read();
    check("fe_cleared", {31'd0, frame_error}, 0);
    check("fe_avail_cleared", {31'd0, rx_available}, 0);
    check("fe_data_kept", {24'd0, data_out}, 32'h0F);
    repeat (5) @(negedge clk);

    // Glitch: low for 4 cycles. This must be rejected with no flag change.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_flags", {29'd0, rx_available, frame_error, overrun}, 0);
    check("glitch_data", {24'd0, data_out}, 32'h0F);
    send_frame(8'hFF, 1'b1, 8'hFF, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    pulse_read();
    repeat (5) @(negedge clk);

    // read_uart held high while 81 completes: a one-cycle availability pulse.
    read_uart = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h81, 1'b1, 8'h81, 1, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("held_ov", {31'd0, overrun}, 0);
    check("held_data", {24'd0, data_out}, 32'h81);
    read_uart = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of a frame, then 7E.
    rx = 1'b0;                                // start bit
    repeat (C) @(negedge clk);
    rx = 1'b1;                                // bits 0..2
    repeat (3 * C) @(negedge clk);
    rx = 1'b0;                                // bit 3
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_data", {24'd0, data_out}, 32'h00);
    check("midrst_flags", {29'd0, rx_available, frame_error, overrun}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("postrst_flags", {29'd0, rx_available, frame_error, overrun}, 0);
    send_frame(8'h7E, 1'b1, 8'h7E, 1, 0, 0, 0);

    // Drain the scoreboard, with a bound.
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("final_data", {24'd0, data_out}, 32'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
